// File: rtl/alarm_pkg.sv
// alarm_pkg: shared state encoding and default timing constants
package alarm_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } state_t;
    localparam int DEF_RING_TIMEOUT_S = 60;
    localparam int DEF_SNOOZE_S       = 300;
    localparam int DEF_MAX_SNOOZE     = 3;
endpackage

// File: rtl/alarm_ring_ctrl_if.sv
// alarm_ring_ctrl_if: tick, key and indicator signals of the alarm ring controller
interface alarm_ring_ctrl_if;
    logic       SEC_TICK;
    logic       BEEP_TICK;
    logic       ALARM_EN;
    logic       MATCH;
    logic       KEY_STOP;
    logic       KEY_SNOOZE;
    logic       BUZZER;
    logic       LED_RING;
    logic       LED_SNOOZE;
    logic [1:0] STATE;
    modport master (
        output SEC_TICK, BEEP_TICK, ALARM_EN, MATCH, KEY_STOP, KEY_SNOOZE,
        input  BUZZER, LED_RING, LED_SNOOZE, STATE
    );
    modport slave (
        input  SEC_TICK, BEEP_TICK, ALARM_EN, MATCH, KEY_STOP, KEY_SNOOZE,
        output BUZZER, LED_RING, LED_SNOOZE, STATE
    );
endinterface

// File: rtl/al_sec_timer.sv
// al_sec_timer: loadable, tick-enabled seconds counter that saturates at 0 or MAX
module al_sec_timer #(
    parameter int MAX  = 60,
    parameter bit DOWN = 1'b0,
    localparam int W   = $clog2(MAX + 1)
)(
    input  logic         CLK,
    input  logic         RESET,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         tick,
    output logic [W-1:0] count
);
    // load has priority over tick; counting stops at the end of the range
    always_ff @(posedge CLK) begin
        if (RESET)
            count <= '0;
        else if (load)
            count <= value;
        else if (tick)
            count <= DOWN ? ((count == '0) ? count : count - W'(1))
                          : ((count == W'(MAX)) ? count : count + W'(1));
    end
endmodule

// File: rtl/alarm_ring_ctrl.sv
// alarm_ring_ctrl: alarm ringing FSM with auto-off timeout and limited snoozes
module alarm_ring_ctrl
    import alarm_pkg::*;
#(
    parameter int RING_TIMEOUT_S = DEF_RING_TIMEOUT_S,
    parameter int SNOOZE_S       = DEF_SNOOZE_S,
    parameter int MAX_SNOOZE     = DEF_MAX_SNOOZE
)(
    input logic          CLK,
    input logic          RESET,
    alarm_ring_ctrl_if.slave bus
);
    localparam int RW = $clog2(RING_TIMEOUT_S + 1);
    localparam int SW = $clog2(SNOOZE_S + 1);
    localparam int CW = $clog2(MAX_SNOOZE + 1);

    state_t        state_q, state_d;
    logic          match_q, buzzer_q, buzzer_d, ring_load, snooze_load;
    logic [CW-1:0] snz_q, snz_d;
    logic [RW-1:0] ring_cnt;
    logic [SW-1:0] snooze_cnt;
    logic          trigger, ring_expire, snooze_expire;

    assign trigger       = bus.MATCH & ~match_q;
    assign ring_expire   = bus.SEC_TICK && (int'(ring_cnt) + 1 >= RING_TIMEOUT_S);
    assign snooze_expire = bus.SEC_TICK && (int'(snooze_cnt) <= 1);

    al_sec_timer #(.MAX(RING_TIMEOUT_S), .DOWN(1'b0)) u_ring (
        .CLK   (CLK),
        .RESET (RESET),
        .load  (ring_load),
        .value ('0),
        .tick  (bus.SEC_TICK && state_q == ST_RING),
        .count (ring_cnt)
    );

    al_sec_timer #(.MAX(SNOOZE_S), .DOWN(1'b1)) u_snooze (
        .CLK   (CLK),
        .RESET (RESET),
        .load  (snooze_load),
        .value (SW'(SNOOZE_S)),
        .tick  (bus.SEC_TICK && state_q == ST_SNOOZE),
        .count (snooze_cnt)
    );

    // state, buzzer, snooze count and MATCH edge-detect registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            buzzer_q <= 1'b0;
            snz_q    <= '0;
            match_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            buzzer_q <= buzzer_d;
            snz_q    <= snz_d;
            match_q  <= bus.MATCH;
        end
    end

    // next state: disable beats everything, keys beat timer events, stop beats snooze
    always_comb begin
        state_d     = state_q;
        buzzer_d    = 1'b0;
        snz_d       = snz_q;
        ring_load   = 1'b0;
        snooze_load = 1'b0;
        if (!bus.ALARM_EN) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (trigger) begin
                    state_d   = ST_RING;
                    buzzer_d  = 1'b1;
                    ring_load = 1'b1;
                    snz_d     = '0;
                end
                ST_RING: if (bus.KEY_STOP) begin
                    state_d = ST_IDLE;
                end else if (bus.KEY_SNOOZE && snz_q < CW'(MAX_SNOOZE)) begin
                    state_d     = ST_SNOOZE;
                    snz_d       = snz_q + CW'(1);
                    snooze_load = 1'b1;
                end else if (ring_expire) begin
                    state_d = ST_IDLE;
                end else begin
                    buzzer_d = buzzer_q ^ bus.BEEP_TICK;
                end
                ST_SNOOZE: if (bus.KEY_STOP) begin
                    state_d = ST_IDLE;
                end else if (snooze_expire) begin
                    state_d   = ST_RING;
                    buzzer_d  = 1'b1;
                    ring_load = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign bus.BUZZER     = buzzer_q;
    assign bus.STATE      = state_q;
    assign bus.LED_RING   = state_q == ST_RING;
    assign bus.LED_SNOOZE = state_q == ST_SNOOZE;
endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// tb_alarm_ring_ctrl: directed + random stimulus, scoreboard against a behavioural alarm model
module tb_alarm_ring_ctrl;
    localparam int RT = 5;
    localparam int SS = 3;
    localparam int MS = 2;

    typedef struct {
        int         due;
        logic [4:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pc = 0;
    int   compared = 0;
    int   mismatched = 0;
    exp_t q[$];

    int mode = 0;
    int ring_secs = 0;
    int snooze_left = 0;
    int snoozes = 0;
    bit buzz = 1'b0;
    bit prev_m = 1'b1;

    alarm_ring_ctrl_if bus();

    alarm_ring_ctrl #(.RING_TIMEOUT_S(RT), .SNOOZE_S(SS), .MAX_SNOOZE(MS)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pc <= pc + 1;

    // behavioural model: mode 0 idle, 1 ringing, 2 snoozing
    task automatic model(input bit r, s, b, e, m, k, z);
        bit rise;
        if (r) begin
            mode = 0; buzz = 0; ring_secs = 0; snooze_left = 0; snoozes = 0; prev_m = 1;
            return;
        end
        rise = m && !prev_m;
        prev_m = m;
        if (!e) begin
            mode = 0; buzz = 0;
        end else if (mode == 0) begin
            if (rise) begin mode = 1; ring_secs = 0; snoozes = 0; buzz = 1; end
        end else if (mode == 1) begin
            if (k) begin
                mode = 0; buzz = 0;
            end else if (z && snoozes < MS) begin
                mode = 2; snoozes++; snooze_left = SS; buzz = 0;
            end else begin
                if (s) ring_secs++;
                if (ring_secs >= RT) begin mode = 0; buzz = 0; end
                else if (b) buzz = !buzz;
            end
        end else begin
            if (k) begin
                mode = 0; buzz = 0;
            end else if (s) begin
                snooze_left--;
                if (snooze_left <= 0) begin mode = 1; ring_secs = 0; buzz = 1; end
            end
        end
    endtask

    task automatic drive(input bit r, s, b, e, m, k, z);
        @(posedge clk);
        #1;
        rst = r; bus.SEC_TICK = s; bus.BEEP_TICK = b; bus.ALARM_EN = e;
        bus.MATCH = m; bus.KEY_STOP = k; bus.KEY_SNOOZE = z;
        model(r, s, b, e, m, k, z);
        q.push_back('{pc + 1, {2'(mode), buzz, mode == 1, mode == 2}});
    endtask

    task automatic trig();
        drive(0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 1, 0, 0);
    endtask

    task automatic secs(input int n);
        repeat (n) begin
            drive(0, 0, 1, 1, 1, 0, 0);
            drive(0, 1, 0, 1, 1, 0, 0);
        end
    endtask

    task automatic snooze();
        drive(0, 0, 0, 1, 1, 0, 1);
    endtask

    // monitor: every cycle the DUT presents its registered outputs; compare against the due entry
    always @(negedge clk) begin
        exp_t       e;
        logic [4:0] got;
        while (q.size() > 0 && q[0].due <= pc) begin
            e = q.pop_front();
            got = {bus.STATE, bus.BUZZER, bus.LED_RING, bus.LED_SNOOZE};
            compared++;
            if (e.due != pc || got !== e.v) begin
                mismatched++;
                $display("FAIL outputs cycle %0d {state,buzzer,led_ring,led_snooze}: got %b expected %b (due %0d)",
                         pc, got, e.v, e.due);
            end
        end
    end

    initial begin
        bit rm, re;
        bus.SEC_TICK = 0; bus.BEEP_TICK = 0; bus.ALARM_EN = 1;
        bus.MATCH = 1; bus.KEY_STOP = 0; bus.KEY_SNOOZE = 0;
        repeat (2) drive(1, 0, 0, 1, 1, 0, 0);
        repeat (3) drive(0, 0, 0, 1, 1, 0, 0);
        trig();
        secs(5);
        drive(0, 0, 1, 1, 1, 0, 0);
        trig();
        snooze();
        secs(3);
        snooze();
        secs(3);
        snooze();
        secs(1);
        drive(0, 0, 0, 1, 1, 1, 1);
        trig();
        secs(4);
        drive(0, 1, 0, 1, 1, 1, 0);
        trig();
        snooze();
        secs(1);
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 1, 0, 0);
        trig();
        snooze();
        secs(3);
        drive(1, 0, 0, 1, 1, 0, 0);
        trig();
        snooze();
        secs(3);
        snooze();
        secs(3);
        snooze();
        secs(2);
        rm = 0;
        re = 1;
        repeat (3000) begin
            if ($urandom_range(0, 7) == 0) rm = !rm;
            if ($urandom_range(0, 79) == 0) re = 0;
            else if (!re && $urandom_range(0, 3) == 0) re = 1;
            drive($urandom_range(0, 399) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                  re, rm, $urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0);
        end
        drive(0, 0, 0, 1, rm, 0, 0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expected entries left unchecked, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
